// File: rtl/spy_ctrl_pkg.sv
// Shared types for the spy-chain trial sequencer: FSM encoding, minimum settle
// length and the burst result record.
package spy_ctrl_pkg;

  localparam int SPY_MIN_SETTLE = 2;
  localparam int SPY_RES_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_CHECK   = 3'd5,
    ST_REPORT  = 3'd6
  } spy_ctrl_state_t;

  typedef struct packed {
    logic [SPY_RES_W-1:0] err_count;
    logic [SPY_RES_W-1:0] trial_count;
  } spy_result_t;

endpackage

// File: rtl/spy_chain_sampler_ctrl_if.sv
// Control/readout bundle between the burst requester and the spy sampler.
interface spy_chain_sampler_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 4
);
  logic             start;
  logic [CNT_W-1:0] num_trials;
  logic [GAP_W-1:0] launch_gap;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] trial_count;

  modport master (
    output start, num_trials, launch_gap, res_ready,
    input  busy, res_valid, err_count, trial_count
  );

  modport slave (
    input  start, num_trials, launch_gap, res_ready,
    output busy, res_valid, err_count, trial_count
  );
endinterface

// File: rtl/spy_capture_sync.sv
// Enable-gated capture flop on the chain output plus one resync flop; kept as
// its own module so the capture flop can be pinned next to the chain.
module spy_capture_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_cap_en,
  input  logic i_path_out,
  output logic o_cap_sync
);
  logic r_cap;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cap  <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      if (i_cap_en) r_cap <= i_path_out;
      r_sync <= r_cap;
    end
  end

  assign o_cap_sync = r_sync;
endmodule

// File: rtl/spy_chain_sampler_ctrl.sv
// Trial sequencer for a spy delay chain: launch, capture after a gap, count late
// arrivals. Define SPY_SAMPLE_LOG_EN to add the 32-bit per-trial mismatch log.
module spy_chain_sampler_ctrl
  import spy_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int GAP_W      = 4,
  parameter int SETTLE_CYC = 8,
  parameter bit EXPECT_INV = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spy_chain_sampler_ctrl_if.slave    bus,
  output logic                       path_in,
  input  logic                       path_out
`ifdef SPY_SAMPLE_LOG_EN
  ,
  output logic [31:0]                sample_log
`endif
);
  localparam int SETTLE_EFF = (SETTLE_CYC < SPY_MIN_SETTLE) ? SPY_MIN_SETTLE : SETTLE_CYC;
  localparam int SET_W      = $clog2(SETTLE_EFF + 1);

  spy_ctrl_state_t  r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_trials;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [SET_W-1:0] r_set_cnt;
  logic             r_path_in;
  logic             r_expect;
  logic             w_cap_en;
  logic             w_cap_sync;
  logic             w_accept;
  logic             w_mismatch;

  assign w_accept   = (r_state == ST_IDLE) && bus.start;
  // Capture edge is the one closing the last WAIT cycle, i.e. launch_gap edges after launch.
  assign w_cap_en   = (r_state == ST_WAIT) && (r_gap_cnt == GAP_W'(1));
  assign w_mismatch = w_cap_sync ^ r_expect;

  spy_capture_sync u_cap (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cap_en   (w_cap_en),
    .i_path_out (path_out),
    .o_cap_sync (w_cap_sync)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_num     <= '0;
      r_err     <= '0;
      r_trials  <= '0;
      r_gap     <= GAP_W'(1);
      r_gap_cnt <= '0;
      r_set_cnt <= '0;
      r_path_in <= 1'b0;
      r_expect  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_num     <= bus.num_trials;
            r_gap     <= (bus.launch_gap == '0) ? GAP_W'(1) : bus.launch_gap;
            r_err     <= '0;
            r_trials  <= '0;
            r_set_cnt <= SET_W'(SETTLE_EFF - 1);
            r_state   <= (bus.num_trials == '0) ? ST_REPORT : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_set_cnt == '0) r_state   <= ST_LAUNCH;
          else                 r_set_cnt <= r_set_cnt - SET_W'(1);
        end
        ST_LAUNCH: begin
          r_path_in <= ~r_path_in;
          r_expect  <= ~r_path_in ^ EXPECT_INV;
          r_gap_cnt <= r_gap;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_cap_en) r_state   <= ST_CAPTURE;
          else          r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
        ST_CAPTURE: r_state <= ST_CHECK;
        ST_CHECK: begin
          r_trials <= r_trials + CNT_W'(1);
          if (w_mismatch && (r_err != '1)) r_err <= r_err + CNT_W'(1);
          if (r_trials + CNT_W'(1) == r_num) begin
            r_state <= ST_REPORT;
          end else begin
            r_set_cnt <= SET_W'(SETTLE_EFF - 1);
            r_state   <= ST_SETTLE;
          end
        end
        ST_REPORT: if (bus.res_ready) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPY_SAMPLE_LOG_EN
  logic [31:0] r_log;

  always_ff @(posedge clk) begin
    if (!rst_n)                    r_log <= '0;
    else if (w_accept)             r_log <= '0;
    else if (r_state == ST_CHECK)  r_log <= {r_log[30:0], w_mismatch};
  end

  assign sample_log = r_log;
`endif

  assign path_in         = r_path_in;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.res_valid   = (r_state == ST_REPORT);
  assign bus.err_count   = r_err;
  assign bus.trial_count = r_trials;
endmodule

// File: tb/tb_spy_chain_sampler_ctrl.sv
// Scoreboard bench for spy_chain_sampler_ctrl with a transport-delay chain model.
module tb_spy_chain_sampler_ctrl;
  import spy_ctrl_pkg::*;

  localparam int CNT_W  = 4;
  localparam int GAP_W  = 4;
  localparam int SETTLE = 8;

  typedef struct {
    spy_result_t res;
    logic [31:0] log;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic path_in;
  logic path_out = 1'b0;
`ifdef SPY_SAMPLE_LOG_EN
  logic [31:0] sample_log;
`endif

  int   n_chk = 0;
  int   n_err = 0;
  int   tb_pin = 0;
  int   d_rise = 25;
  int   d_fall = 25;
  exp_t sb[$];

  spy_chain_sampler_ctrl_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  spy_chain_sampler_ctrl #(
    .CNT_W(CNT_W), .GAP_W(GAP_W), .SETTLE_CYC(SETTLE), .EXPECT_INV(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .path_in    (path_in),
    .path_out   (path_out)
`ifdef SPY_SAMPLE_LOG_EN
    ,
    .sample_log (sample_log)
`endif
  );

  always #5 clk = ~clk;

  // Chain model: direction-dependent transport delay, 10 time units per cycle.
  always @(path_in) path_out <= #(path_in ? d_rise : d_fall) path_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic run_burst(input int n, input int g, input int dr, input int df,
                           input bit hs_start, input bit poke);
    exp_t e;
    int   ge, pin, err, c, exp_c;
    logic last_pin;
    int   launches[$];
    ge = (g == 0) ? 1 : g;
    d_rise = dr;
    d_fall = df;
    pin = tb_pin;
    err = 0;
    e.log = '0;
    for (int i = 0; i < n; i++) begin
      int v, d;
      bit f;
      v = pin ^ 1;
      d = (v != 0) ? dr : df;
      f = !(d < ge * 10);
      if (f && err < 15) err++;
      e.log = {e.log[30:0], f};
      pin = v;
    end
    e.res.err_count   = SPY_RES_W'(err);
    e.res.trial_count = SPY_RES_W'(n);
    sb.push_back(e);
    tb_pin = pin;

    @(negedge clk);
    bus.start      = 1'b1;
    bus.num_trials = CNT_W'(n);
    bus.launch_gap = GAP_W'(g);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_on", bus.busy, 1);
    last_pin = path_in;
    c = 0;
    while (!bus.res_valid && c < 2000) begin
      @(posedge clk); #1;
      c++;
      if (poke) begin
        bus.start      = (c == 3);
        bus.num_trials = CNT_W'(1);
      end
      if (path_in !== last_pin) begin
        launches.push_back(c);
        last_pin = path_in;
      end
    end
    bus.start = 1'b0;
    exp_c = (n == 0) ? 0 : SETTLE + 1 + (n - 1) * (SETTLE + 3 + ge) + ge + 2;
    chk("rv_cycle", c, exp_c);
    chk("n_launch", launches.size(), n);
    if (n >= 1) chk("first_launch", launches[0], SETTLE + 1);
    if (n >= 2) chk("launch_gap", launches[1] - launches[0], SETTLE + 3 + ge);
    chk("pin_track", path_in, tb_pin);

    e = sb.pop_front();
    chk("err_count", bus.err_count, e.res.err_count);
    chk("trial_count", bus.trial_count, e.res.trial_count);
`ifdef SPY_SAMPLE_LOG_EN
    chk("sample_log", sample_log, e.log);
`endif
    repeat (2) @(negedge clk);
    chk("rv_hold", bus.res_valid, 1);
    chk("err_frozen", bus.err_count, e.res.err_count);

    bus.res_ready = 1'b1;
    bus.start     = hs_start;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    chk("rv_drop", bus.res_valid, 0);
    chk("busy_off", bus.busy, 0);
    @(posedge clk); #1;
    chk("idle_stays", bus.busy, 0);
  endtask

  initial begin
    int c, nl;
    logic last_pin;
    bus.start      = 1'b0;
    bus.res_ready  = 1'b0;
    bus.num_trials = '0;
    bus.launch_gap = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_path_in", path_in, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rv", bus.res_valid, 0);
    chk("rst_err", bus.err_count, 0);
    chk("rst_trials", bus.trial_count, 0);
`ifdef SPY_SAMPLE_LOG_EN
    chk("rst_log", sample_log, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_burst(10, 4, 25, 25, 1'b0, 1'b0);
    run_burst(10, 2, 25, 25, 1'b0, 1'b0);
    run_burst(5,  0, 5,  5,  1'b0, 1'b0);
    run_burst(0,  3, 25, 25, 1'b1, 1'b0);
    run_burst(15, 2, 25, 25, 1'b0, 1'b0);
    run_burst(3,  2, 25, 25, 1'b0, 1'b0);
    run_burst(6,  2, 5,  25, 1'b0, 1'b1);

    // Abandon a burst during WAIT of trial 5.
    d_rise = 25;
    d_fall = 25;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.num_trials = CNT_W'(10);
    bus.launch_gap = GAP_W'(4);
    @(posedge clk); #1;
    bus.start = 1'b0;
    last_pin = path_in;
    c = 0;
    nl = 0;
    while (nl < 5 && c < 2000) begin
      @(posedge clk); #1;
      c++;
      if (path_in !== last_pin) begin
        nl++;
        last_pin = path_in;
      end
    end
    chk("rst_reach_t5", nl, 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_pin", path_in, 0);
    chk("mid_rst_rv", bus.res_valid, 0);
    chk("mid_rst_trials", bus.trial_count, 0);
    rst_n = 1'b1;
    tb_pin = 0;
    run_burst(10, 4, 25, 25, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spy_chain_sampler_ctrl.md
# spy_chain_sampler_ctrl

Trial sequencer for the chained spy delay paths, e.g. the 50-stage, non-inverting `singlepath_3_spy_p25` chain.
- Per trial: drive a transition into the chain's `pathInput`, capture `pathResult` a programmable number of clock cycles later, and compare the capture with the expected settled value.
- Late arrivals are counted over a burst of trials.
- Sits between the control/readout logic and one chain instance. Chain delay is inferred from the failure rate versus launch gap.

## Interface
- `CNT_W`, 16: width of the trial count and error count.
- `GAP_W`, 4: width of the launch-to-sample gap field.
- `SETTLE_CYC`, 8: idle cycles between trials so the chain fully settles; must be ≥2.
- `EXPECT_INV`, 0: chain parity. 0 means an even number of inverting stages, so the expected value equals the launched value. 1 means odd.
- `clk` in 1: single clock. Sync flops and counters run on it.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: single-cycle request to begin a burst. Accepted only in IDLE.
- `num_trials` in CNT_W: number of trials. Sampled when `start` is accepted.
- `launch_gap` in GAP_W: cycles from launch edge to capture edge. Sampled when `start` is accepted; 0 is treated as 1.
- `path_in` out 1: registered drive to the chain input.
- `path_out` in 1: chain output; asynchronous to the launch timing.
- `busy` out 1: high in every state except IDLE.
- `res_valid` out 1: result available. Held until the handshake completes.
- `res_ready` in 1: consumer accepts the result.
- `err_count` out CNT_W: number of trials whose capture mismatched the expected value. Saturates.
- `trial_count` out CNT_W: number of trials executed in the burst.

## Operation
- FSM states: IDLE, SETTLE, LAUNCH, WAIT, CAPTURE, CHECK, REPORT.
- IDLE: `start` latches `num_trials` and `launch_gap` (0→1), clears both counters, and moves to SETTLE. If the latched `num_trials`=0, move directly to REPORT instead.
- SETTLE: count `SETTLE_CYC` cycles with `path_in` static, then go to LAUNCH.
- LAUNCH: toggle `path_in` for one cycle. Record the expected value as new `path_in` ^ `EXPECT_INV`. Load the gap counter and go to WAIT.
- WAIT: decrement the gap counter. When it expires, assert the capture enable.
- The capture flop samples `path_out` on the edge exactly `launch_gap` cycles after the `path_in` edge. The captured bit then passes through one resynchronising flop (CAPTURE state).
- CHECK:
  - `trial_count`++.
  - If synced capture ≠ expected, `err_count`++ (saturating at all-ones).
  - If `trial_count` = `num_trials`, go to REPORT; otherwise go to SETTLE.
- Trials alternate rising and falling launches. The first launch of a burst is rising if `path_in`=0 at that point.
- REPORT: `res_valid`=1 and the counters are frozen. On `res_valid && res_ready`, go to IDLE the same edge.
- `start` is ignored while `busy`=1. `res_ready` is ignored outside REPORT.
- Reset during any state: all outputs return to reset values at the next edge and the burst is abandoned; there is no partial report.

## Timing
- Reset values:
  - `path_in`=0, `busy`=0, `res_valid`=0, `err_count`=0, `trial_count`=0, FSM=IDLE.
  - With the macro below: `sample_log`=0.
- `start` accepted at edge T → `busy`=1 after T. The first launch edge is T+1+`SETTLE_CYC`.
- One trial takes `SETTLE_CYC` + 1 + `launch_gap` + 2 cycles.
- `res_valid` rises on the edge after the final CHECK.
- A `start` and `res_ready` arriving in the same cycle while in REPORT: the handshake completes and `start` is ignored. A new burst needs `start` in IDLE.

## Configuration
- `SPY_SAMPLE_LOG_EN` defined:
  - Adds output `sample_log` [31:0].
  - Each CHECK shifts in 1 on mismatch and 0 on match, LSB newest.
  - Cleared on accepted `start`; frozen in REPORT.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `spy_ctrl_pkg` holds:
  - the FSM state enum `spy_ctrl_state_t`;
  - the `SPY_MIN_SETTLE`=2 constant;
  - the result struct {`err_count`, `trial_count`}.
- One sub-module, `spy_capture_sync`, contains the capture flop (enable-gated) and the resync flop. It is kept separate so placement constraints can pin the capture flop beside the chain output.
- The chain instance lives outside this block.

## Test plan
- Behavioural chain model with 2.5-cycle delay, `EXPECT_INV`=0, `launch_gap`=4, `num_trials`=10 → `err_count`=0, `trial_count`=10; `res_valid` high until `res_ready`.
- Same model, `launch_gap`=2 → `err_count`=10. `path_in` alternates 0→1→0, with launch edges `SETTLE_CYC`+5 cycles apart.
- `launch_gap`=0, delay 0.5 cycle → behaves as gap 1, `err_count`=0. `num_trials`=0 → `res_valid` one cycle after `start`, both counts 0.
- `CNT_W`=4, 20 trials, all failing → `err_count`=15 (saturated), `trial_count`=20 mod 16... illegal for `CNT_W`=4. Use `num_trials`=15 with failures forced → `err_count`=15. Then accept the result, start 3 more, and check `err_count` clears to 3.
- `rst_n` low during WAIT of trial 5 → next edge `busy`=0 and `path_in`=0. A subsequent `start` runs a clean full burst.
- `SPY_SAMPLE_LOG_EN`, a model failing only on falling launches, 6 trials → `sample_log`=6'b101010; `start` asserted while busy has no effect.
